// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece ids, checker FSM state type and the
// 4x4 occupancy mask for every piece. The board writer uses the same
// shape_mask() function, so both blocks always agree on the piece geometry.
// No ports (package).
package tetris_pkg;

  typedef logic [2:0] t_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam t_id_t T_NONE = 3'd0;
  localparam t_id_t T_I    = 3'd1;
  localparam t_id_t T_O    = 3'd2;
  localparam t_id_t T_T    = 3'd3;
  localparam t_id_t T_S    = 3'd4;
  localparam t_id_t T_Z    = 3'd5;
  localparam t_id_t T_J    = 3'd6;
  localparam t_id_t T_L    = 3'd7;

  // Bit r*4+c set means row r, column c of the bounding box is filled.
  function automatic logic [15:0] shape_mask(input t_id_t t);
    logic [15:0] m;
    case (t)
      T_I:     m = 16'h00F0;
      T_O:     m = 16'h0066;
      T_T:     m = 16'h0072;
      T_S:     m = 16'h0036;
      T_Z:     m = 16'h0063;
      T_J:     m = 16'h0071;
      T_L:     m = 16'h0074;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tetromino_collision_checker_if.sv
// Request/response link between the move/rotate controller (master) and the
// collision checker (slave).
//   start      master->slave  request, held high until done is seen
//   in_x,in_y  master->slave  top-left of the 4x4 box (sampled with start)
//   t_id       master->slave  piece id
//   collision  slave->master  result, valid while done=1
//   done       slave->master  check complete
// Handshake: start acts as valid and done as the acknowledge. A query is
// accepted on the first clock edge where the checker is idle and start=1;
// it completes on the edge where done=1 and start=1. The master must then
// drop start for at least one cycle before issuing the next query; start
// held high while done=1 never starts a second check.
interface tetromino_collision_checker_if;
  import tetris_pkg::*;

  logic       start;
  logic [4:0] in_x;
  logic [4:0] in_y;
  t_id_t      t_id;
  logic       collision;
  logic       done;

  modport master (output start, in_x, in_y, t_id, input collision, done);
  modport slave  (input start, in_x, in_y, t_id, output collision, done);

endinterface

// File: rtl/tetromino_shape_rom.sv
// Combinational piece-id to 4x4 occupancy mask lookup.
//   t_id  in   piece id (0 = none)
//   mask  out  16-bit mask, bit r*4+c = row r, column c
module tetromino_shape_rom
  import tetris_pkg::*;
(
  input  t_id_t       t_id,
  output logic [15:0] mask
);

  assign mask = shape_mask(t_id);

endmodule

// File: rtl/tetromino_collision_checker.sv
// Tetromino collision checker: scans the 16 cells of a piece's bounding box at
// a candidate position, reads the board RAM for every filled in-bounds cell
// and reports a hit if any cell is occupied or lies past the right wall or
// the floor.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   bus          tetromino_collision_checker_if.slave (start/in_x/in_y/t_id
//                in, collision/done out)
//   x, y, rden   board RAM read address and enable (one cell per cycle)
//   rd_data      cell id returned RD_LAT cycles after rden, 0 = empty
//   state_dbg    current FSM state, for observation only
// Optional build macro TETRIS_EARLY_EXIT_EN: stop scanning on the first hit
// and go straight to the drain phase. Without it every check takes exactly
// 1 + 16 + RD_LAT cycles.
module tetromino_collision_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int RD_LAT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  tetromino_collision_checker_if.slave bus,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       rden,
  input  logic [2:0] rd_data,
  output chk_state_t state_dbg
);

  chk_state_t  state;
  logic [3:0]  idx;
  logic        latch;
  logic        finish;
  logic        stop_scan;
  logic [15:0] mask;
  t_id_t       t_id_q;

  tetromino_collision_checker_ctrl #(.RD_LAT(RD_LAT)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .stop_scan (stop_scan),
    .state     (state),
    .idx       (idx),
    .latch     (latch),
    .finish    (finish),
    .done      (bus.done)
  );

  tetromino_collision_checker_data #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .RD_LAT  (RD_LAT)
  ) u_data (
    .clk       (clk),
    .reset     (reset),
    .latch     (latch),
    .finish    (finish),
    .state     (state),
    .idx       (idx),
    .in_x      (bus.in_x),
    .in_y      (bus.in_y),
    .t_id      (bus.t_id),
    .mask      (mask),
    .rd_data   (rd_data),
    .t_id_q    (t_id_q),
    .x         (x),
    .y         (y),
    .rden      (rden),
    .collision (bus.collision),
    .stop_scan (stop_scan)
  );

  tetromino_shape_rom u_rom (
    .t_id (t_id_q),
    .mask (mask)
  );

  assign state_dbg = state;

endmodule

// Control half: FSM, cell index counter and drain counter.
module tetromino_collision_checker_ctrl
  import tetris_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop_scan,
  output chk_state_t state,
  output logic [3:0] idx,
  output logic       latch,
  output logic       finish,
  output logic       done
);

  logic [1:0] drain_cnt;

  // latch: the cycle the query inputs are captured; finish: last drain cycle,
  // when the final read result is on rd_data.
  assign latch  = (state == IDLE) && start;
  assign finish = (state == DRAIN) && (drain_cnt == 2'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      drain_cnt <= 2'd0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SCAN;
            idx   <= 4'd0;
          end
        end
        SCAN: begin
          idx <= idx + 4'd1;
          if (idx == 4'd15 || stop_scan) begin
            state     <= DRAIN;
            drain_cnt <= 2'd0;
          end
        end
        DRAIN: begin
          if (finish) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Datapath half: latched query, cell coordinate adders, bounds compare,
// read-tracking pipeline and the sticky hit / collision registers.
module tetromino_collision_checker_data
  import tetris_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch,
  input  logic        finish,
  input  chk_state_t  state,
  input  logic [3:0]  idx,
  input  logic [4:0]  in_x,
  input  logic [4:0]  in_y,
  input  t_id_t       t_id,
  input  logic [15:0] mask,
  input  logic [2:0]  rd_data,
  output t_id_t       t_id_q,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic        rden,
  output logic        collision,
  output logic        stop_scan
);

  localparam logic [5:0] W_LIM = 6'(BOARD_W);
  localparam logic [5:0] H_LIM = 6'(BOARD_H);

  logic [4:0]        bx, by;
  logic [5:0]        cx, cy;
  logic              cell_on, oob, oob_hit, data_hit, hit;
  logic [RD_LAT-1:0] rd_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      bx     <= 5'd0;
      by     <= 5'd0;
      t_id_q <= T_NONE;
    end else if (latch) begin
      bx     <= in_x;
      by     <= in_y;
      t_id_q <= t_id;
    end
  end

  // 6-bit sums so a box hanging past column 31 / row 31 still compares as
  // out of bounds instead of wrapping back onto the board.
  assign cx = {1'b0, bx} + {4'b0, idx[1:0]};
  assign cy = {1'b0, by} + {4'b0, idx[3:2]};

  assign cell_on = (state == SCAN) && mask[idx];
  assign oob     = (cx >= W_LIM) || (cy >= H_LIM);
  assign oob_hit = cell_on && oob;
  assign rden    = cell_on && !oob;
  assign x       = rden ? cx[4:0] : 5'd0;
  assign y       = rden ? cy[4:0] : 5'd0;

  // The flag marks which rd_data beats belong to a read we issued; rd_data
  // on any other cycle is meaningless and must be ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rden;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign data_hit = rd_pipe[RD_LAT-1] && (rd_data != 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit <= 1'b0;
    end else if (latch) begin
      hit <= 1'b0;
    end else if (oob_hit || data_hit) begin
      hit <= 1'b1;
    end
  end

  // Result is captured once per query so it stays stable through DONE and
  // the following IDLE, even after the next query clears hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision <= 1'b0;
    end else if (finish) begin
      collision <= hit || data_hit;
    end
  end

`ifdef TETRIS_EARLY_EXIT_EN
  assign stop_scan = hit || oob_hit || data_hit;
`else
  assign stop_scan = 1'b0;
`endif

endmodule

// File: tb/tb_tetromino_collision_checker.sv
// Bench for tetromino_collision_checker: two instances (RD_LAT=1 and 2) share
// one request stream and one board; each has its own latency-accurate RAM
// model that returns random junk whenever no read was issued.
module tb_tetromino_collision_checker;
  import tetris_pkg::*;

  localparam int BW = 10;
  localparam int BH = 20;
`ifdef TETRIS_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic       q_start;
  logic [4:0] q_x, q_y;
  logic [2:0] q_t;

  tetromino_collision_checker_if bus0 ();
  tetromino_collision_checker_if bus1 ();
  assign bus0.start = q_start;
  assign bus0.in_x  = q_x;
  assign bus0.in_y  = q_y;
  assign bus0.t_id  = q_t;
  assign bus1.start = q_start;
  assign bus1.in_x  = q_x;
  assign bus1.in_y  = q_y;
  assign bus1.t_id  = q_t;

  logic [4:0] x0, y0, x1, y1;
  logic       rden0, rden1;
  logic [2:0] rd0, rd1;
  chk_state_t st0, st1;

  tetromino_collision_checker #(.BOARD_W(BW), .BOARD_H(BH), .RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave),
    .x(x0), .y(y0), .rden(rden0), .rd_data(rd0), .state_dbg(st0)
  );
  tetromino_collision_checker #(.BOARD_W(BW), .BOARD_H(BH), .RD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .x(x1), .y(y1), .rden(rden1), .rd_data(rd1), .state_dbg(st1)
  );

  // ---------------- board RAM models ----------------
  logic [2:0] board [0:BW-1][0:BH-1];
  logic [2:0] p0, p1a, p1b;
  always @(posedge clk) begin
    p0  <= rden0 ? board[x0][y0] : 3'($urandom_range(1, 7));
    p1a <= rden1 ? board[x1][y1] : 3'($urandom_range(1, 7));
    p1b <= p1a;
  end
  assign rd0 = p0;
  assign rd1 = p1b;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q0[$];   // {cycle offset, x, y} of each expected read
  logic [15:0] exp_q1[$];
  logic [9:0]  log0[$];     // observed read addresses of dut0
  int  exp_lat[2], exp_col[2];
  int  lat_seen[2], col_seen[2], nrd[2];
  int  rcount[2] = '{0, 0};
  int  t0 = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Piece pictures, row 0 at the top, column 0 at the left.
  function automatic bit in_shape(input int t, input int r, input int c);
    string rows[4];
    rows = '{"....", "....", "....", "...."};
    case (t)
      1: rows[1] = "XXXX";
      2: begin rows[0] = ".XX."; rows[1] = ".XX."; end
      3: begin rows[0] = ".X.."; rows[1] = "XXX."; end
      4: begin rows[0] = ".XX."; rows[1] = "XX.."; end
      5: begin rows[0] = "XX.."; rows[1] = ".XX."; end
      6: begin rows[0] = "X..."; rows[1] = "XXX."; end
      7: begin rows[0] = "..X."; rows[1] = "XXX."; end
      default: ;
    endcase
    return rows[r][c] == "X";
  endfunction

  // Reference: which reads happen at which cycle, result, and done latency.
  task automatic model(input int d, input int px, input int py, input int pt, input int lat);
    int hit_at, col, ex, cx, cy;
    hit_at = 99;
    col = 0;
    for (int k = 0; k < 16; k++) begin
      if (in_shape(pt, k / 4, k % 4)) begin
        cx = px + k % 4;
        cy = py + k / 4;
        if (cx >= BW || cy >= BH) begin
          col = 1;
          if (k < hit_at) hit_at = k;
        end else if (board[cx][cy] != 0) begin
          col = 1;
          if (k + lat < hit_at) hit_at = k + lat;  // noticed when the data returns
        end
      end
    end
    ex = 15;
    if (EARLY && hit_at <= 15) ex = hit_at;
    for (int k = 0; k <= ex; k++) begin
      cx = px + k % 4;
      cy = py + k / 4;
      if (in_shape(pt, k / 4, k % 4) && cx < BW && cy < BH) begin
        if (d == 0) exp_q0.push_back({6'(k + 1), 5'(cx), 5'(cy)});
        else        exp_q1.push_back({6'(k + 1), 5'(cx), 5'(cy)});
      end
    end
    exp_lat[d] = ex + 2 + lat;
    exp_col[d] = col;
  endtask

  // ---------------- compare process ----------------
  task automatic check_read(input int d, input logic [4:0] ax, input logic [4:0] ay);
    logic [15:0] want;
    int rel;
    bit empty;
    rel = cycle - t0;
    rcount[d]++;
    if (d == 0) log0.push_back({ax, ay});
    empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL read%0d: unexpected read at offset %0d x=%0d y=%0d", d, rel, ax, ay);
    end else begin
      if (d == 0) want = exp_q0.pop_front();
      else        want = exp_q1.pop_front();
      if ({6'(rel), ax, ay} != want) begin
        errors++;
        $display("FAIL read%0d: got offset=%0d x=%0d y=%0d, expected offset=%0d x=%0d y=%0d",
                 d, rel, ax, ay, want[15:10], want[9:5], want[4:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rden0) check_read(0, x0, y0);
    if (mon_en && rden1) check_read(1, x1, y1);
  end

  // ---------------- driver ----------------
  task automatic run_query(input int px, input int py, input int pt, input bit scramble);
    bit s0, s1;
    int b0, b1;
    model(0, px, py, pt, 1);
    model(1, px, py, pt, 2);
    b0 = rcount[0];
    b1 = rcount[1];
    s0 = 0; s1 = 0;
    lat_seen = '{0, 0};
    col_seen = '{0, 0};
    q_x = 5'(px); q_y = 5'(py); q_t = 3'(pt);
    q_start = 1'b1;
    t0 = cycle;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (scramble && n == 3) begin
        q_x = 5'($urandom_range(0, 31));
        q_y = 5'($urandom_range(0, 31));
        q_t = 3'($urandom_range(0, 7));
      end
      if (!s0 && bus0.done) begin s0 = 1; lat_seen[0] = n; col_seen[0] = bus0.collision; end
      if (!s1 && bus1.done) begin s1 = 1; lat_seen[1] = n; col_seen[1] = bus1.collision; end
      if (s0 && s1) break;
    end
    chk("done0_timeout", int'(s0), 1);
    chk("done1_timeout", int'(s1), 1);
    chk("latency0", lat_seen[0], exp_lat[0]);
    chk("latency1", lat_seen[1], exp_lat[1]);
    chk("collision0", col_seen[0], exp_col[0]);
    chk("collision1", col_seen[1], exp_col[1]);
    @(negedge clk);
    chk("done0_held", int'(bus0.done), 1);
    chk("done1_held", int'(bus1.done), 1);
    q_start = 1'b0;
    @(negedge clk);
    chk("done0_drop", int'(bus0.done), 0);
    chk("done1_drop", int'(bus1.done), 0);
    chk("collision0_idle", int'(bus0.collision), exp_col[0]);
    chk("collision1_idle", int'(bus1.collision), exp_col[1]);
    chk("missing_reads0", exp_q0.size(), 0);
    chk("missing_reads1", exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
    nrd[0] = rcount[0] - b0;
    nrd[1] = rcount[1] - b1;
  endtask

  task automatic clear_board();
    for (int i = 0; i < BW; i++)
      for (int j = 0; j < BH; j++) board[i][j] = 3'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, dens;
    q_start = 0; q_x = 0; q_y = 0; q_t = 0;
    clear_board();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rden0", int'(rden0), 0);
    chk("reset_rden1", int'(rden1), 0);
    chk("reset_xy0", int'({x0, y0}), 0);
    chk("reset_done0", int'(bus0.done), 0);
    chk("reset_coll0", int'(bus0.collision), 0);
    chk("reset_state0", int'(st0), int'(IDLE));
    chk("reset_state1", int'(st1), int'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // O at (0,0) on an empty board
    base = log0.size();
    run_query(0, 0, 2, 1'b1);
    chk("o_reads", nrd[0], 4);
    chk("o_latency", lat_seen[0], 18);
    chk("o_collision", col_seen[0], 0);
    chk("o_rd_a", int'(log0[base + 0]), (1 << 5) | 0);
    chk("o_rd_b", int'(log0[base + 1]), (2 << 5) | 0);
    chk("o_rd_c", int'(log0[base + 2]), (1 << 5) | 1);
    chk("o_rd_d", int'(log0[base + 3]), (2 << 5) | 1);

    // I at (7,0): cell (10,1) past the right wall
    run_query(7, 0, 1, 1'b0);
    chk("i_wall_reads", nrd[0], 3);
    chk("i_wall_coll", col_seen[0], 1);
    chk("i_wall_lat0", lat_seen[0], EARLY ? 10 : 18);
    chk("i_wall_lat1", lat_seen[1], EARLY ? 11 : 19);

    // occupied floor cell (5,19)
    board[5][19] = 3'd3;
    run_query(3, 18, 3, 1'b0);
    chk("t_floor_hit", col_seen[0], 1);
    run_query(2, 18, 3, 1'b0);
    chk("t_floor_miss", col_seen[0], 0);
    clear_board();

    // no piece
    run_query(4, 4, 0, 1'b0);
    chk("none_reads0", nrd[0], 0);
    chk("none_reads1", nrd[1], 0);
    chk("none_lat", lat_seen[0], 18);
    chk("none_coll", col_seen[0], 0);

    // reset during the 8th scan cycle (collision is 1 beforehand)
    run_query(7, 0, 1, 1'b0);
    mon_en = 1'b0;
    q_x = 5'd3; q_y = 5'd3; q_t = 3'd2; q_start = 1'b1;
    repeat (8) @(negedge clk);
    chk("scan_before_reset", int'(st0), int'(SCAN));
    reset = 1'b1;
    q_start = 1'b0;
    @(negedge clk);
    chk("abort_rden0", int'(rden0), 0);
    chk("abort_rden1", int'(rden1), 0);
    chk("abort_done0", int'(bus0.done), 0);
    chk("abort_coll0", int'(bus0.collision), 0);
    chk("abort_coll1", int'(bus1.collision), 0);
    chk("abort_state0", int'(st0), int'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    run_query(3, 3, 2, 1'b0);
    chk("after_reset_lat", lat_seen[0], 18);

    // last read cell occupied, slow RAM
    board[6][6] = 3'd5;
    run_query(3, 5, 1, 1'b0);
    chk("last_hit_coll1", col_seen[1], 1);
    chk("last_hit_lat1", lat_seen[1], EARLY ? 13 : 19);
    clear_board();

    // first cell out of bounds (J at column 10)
    run_query(10, 0, 6, 1'b0);
    chk("first_oob_coll1", col_seen[1], 1);
    chk("first_oob_lat0", lat_seen[0], EARLY ? 3 : 18);
    chk("first_oob_lat1", lat_seen[1], EARLY ? 4 : 19);

    // random boards and placements
    for (int q = 0; q < 40; q++) begin
      dens = $urandom_range(0, 40);
      for (int i = 0; i < BW; i++)
        for (int j = 0; j < BH; j++)
          board[i][j] = ($urandom_range(0, 99) < dens) ? 3'($urandom_range(1, 7)) : 3'd0;
      run_query($urandom_range(0, 12), $urandom_range(0, 21), $urandom_range(0, 7), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
